// File: rtl/pipe_pkg.sv
// Shared pipeline types: datapath width, the canonical NOP, and the {pc, instr}
// fetch pair handed between front-end stages.
package pipe_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pair_t;

    function automatic fetch_pair_t mk_pair(input logic [XLEN-1:0] pc,
                                            input logic [XLEN-1:0] instr);
        fetch_pair_t p;
        p.pc    = pc;
        p.instr = instr;
        return p;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline storage slot: a valid bit plus payload, with clear over load.
// The payload only updates on a live load, so it keeps its last value when emptied.
module pipe_slot #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         ld,
    input  logic         d_vld,
    input  logic [W-1:0] d,
    output logic         q_vld,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_vld <= 1'b0;
            q     <= '0;
        end else if (clr) begin
            q_vld <= 1'b0;
        end else if (ld) begin
            q_vld <= d_vld;
            if (d_vld)
                q <= d;
        end
    end

endmodule

// File: rtl/if_id_skid_stage.sv
// IF->ID stage: main ID slot plus one skid slot so if_ready can be registered.
// Also keeps saturating stall/flush event counters.
module if_id_skid_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013),
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  pc_if,
    input  logic [XLEN-1:0]  instr_if,
    input  logic             valid_if,
    output logic             if_ready,
    input  logic             stall,
    input  logic             flush,
    output logic [XLEN-1:0]  pc_id,
    output logic [XLEN-1:0]  instr_id,
    output logic             valid_id,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int              PW      = 2 * XLEN;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PW-1:0] in_pair, id_pair, sk_pair, id_d;
    logic          id_vld, sk_vld, id_dvld, sk_ld;
    logic          accept, advance, buf_nxt, rdy_q;
    logic [CNT_W-1:0] stall_q, flush_q;

    assign accept  = valid_if & rdy_q;
    assign advance = ~stall | ~id_vld;
    assign in_pair = {pc_if, instr_if};

    // Skid contents always drain ahead of new input to preserve order.
    assign id_d    = sk_vld ? sk_pair : in_pair;
    assign id_dvld = sk_vld | accept;
    assign sk_ld   = advance ? sk_vld : accept;

    pipe_slot #(.W(PW)) u_id_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .ld    (advance),
        .d_vld (id_dvld),
        .d     (id_d),
        .q_vld (id_vld),
        .q     (id_pair)
    );

    pipe_slot #(.W(PW)) u_skid_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .ld    (sk_ld),
        .d_vld (accept),
        .d     (in_pair),
        .q_vld (sk_vld),
        .q     (sk_pair)
    );

    always_comb begin
        buf_nxt = 1'b0;
        if (flush)
            buf_nxt = 1'b0;
        else if (advance)
            buf_nxt = sk_vld & accept;
        else
            buf_nxt = sk_vld | accept;
    end

    // Ready is a flop so the hazard unit's stall never reaches fetch combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdy_q <= 1'b1;
        else
            rdy_q <= ~buf_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (id_vld && stall && !flush && stall_q != CNT_MAX)
                stall_q <= stall_q + 1'b1;
            if (flush && flush_q != CNT_MAX)
                flush_q <= flush_q + 1'b1;
        end
    end

    assign if_ready  = rdy_q;
    assign valid_id  = id_vld;
    assign pc_id     = id_pair[PW-1:XLEN];
    assign instr_id  = id_vld ? id_pair[XLEN-1:0] : NOP_INSTR;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: doc/if_id_skid_stage.md
Name: if_id_skid_stage

Overview:
- IF→ID pipeline stage with a 2-entry elastic buffer: a main ID slot plus one skid slot.
- Accepts fetched PC/instruction pairs from the fetch stage and presents them to decode.
- if_ready is registered, so the hazard unit's stall never forms a combinational path back into fetch.
- Produces the per-stage valid bit consumed by downstream 1-bit pipeline control flops.
- Keeps saturating stall/flush performance counters.

Parameters:
- XLEN, 32, PC and instruction width.
- NOP_INSTR, 32'h00000013, instruction driven on instr_id when the ID slot is empty (addi x0,x0,0).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- pc_if  in  XLEN  PC of the fetched instruction.
- instr_if  in  XLEN  fetched instruction.
- valid_if  in  1  fetch offers a pair this cycle.
- if_ready  out  1  stage accepts this cycle (registered).
- stall  in  1  decode cannot advance (from hazard unit).
- flush  in  1  discard all held instructions (branch/jump taken).
- pc_id  out  XLEN  PC in ID slot.
- instr_id  out  XLEN  instruction in ID slot; NOP_INSTR when valid_id=0.
- valid_id  out  1  ID slot holds a live instruction.
- stall_cnt  out  CNT_W  cycles with valid_id=1 and stall=1, saturating.
- flush_cnt  out  CNT_W  cycles with flush=1, saturating.

Behaviour:
- Reset (rst_n=0, async):
  - valid_id=0, buf_valid=0, pc_id=0, instr_id=NOP_INSTR.
  - if_ready=1, stall_cnt=0, flush_cnt=0.
- Definitions:
  - accept = valid_if & if_ready.
  - advance = ~stall | ~valid_id (an empty slot always advances).
- Priority: flush > advance > hold.
- Flush cycle (any other inputs):
  - Next edge: valid_id=0, buf_valid=0, if_ready=1.
  - Input accepted in the same cycle is discarded.
  - instr_id=NOP_INSTR, pc_id holds its old value.
- advance=1:
  - buf_valid=1: ID slot ← skid contents, buf_valid←0, input accepted this cycle (if any) ← skid slot. Ordering is preserved.
  - buf_valid=0: ID slot ← input if accept, else valid_id←0.
- advance=0:
  - ID slot holds.
  - If accept, skid slot ← input, buf_valid←1.
  - accept with buf_valid=1 cannot occur, since if_ready=0 then.
- if_ready next value = ~buf_valid_next.
- Latency: an accepted input with an empty skid appears on the ID outputs one cycle later. Throughput is 1 per cycle with no stall.
- No instruction is lost or duplicated across any stall pattern; only flush drops instructions.
- stall_cnt: +1 on each edge where valid_id & stall & ~flush; holds at 2^CNT_W-1.
- flush_cnt: +1 on each edge where flush=1; holds at 2^CNT_W-1.
- Reset mid-stall: all contents dropped immediately; outputs as listed under Reset.
- valid_if=0 while if_ready=1: no state change except ID draining when advance=1.

Decomposition:
- Shared package pipe_pkg: XLEN, NOP_INSTR, and a struct/type for a {pc, instr} fetch pair, reused by later stages.
- Sub-module pipe_slot: one storage slot with valid, load-enable and clear, async active-low reset. Instantiated twice (ID slot and skid slot).
- Counters and control stay inline.

Test Plan:
- Reset then stream: pcs 0x0,0x4,0x8 with valid_if=1 and stall=0 → pc_id 0x0,0x4,0x8 on consecutive cycles one cycle later; if_ready stays 1.
- Single-cycle stall: stall=1 while ID holds 0x4 and 0x8 is offered → 0x8 captured in skid, if_ready=0 next cycle. Release → ID shows 0x8, then 0xC. stall_cnt=1.
- Long stall of 5 cycles with continuous valid_if → exactly one extra pair held, no loss or duplication, stall_cnt=5.
- Flush while skid full (ID=0x10, skid=0x14) → next cycle valid_id=0, instr_id=0x00000013, if_ready=1, flush_cnt=1. Next accepted pc 0x40 appears on the following cycle.
- Simultaneous flush and stall with valid_if=1 → flush wins, both slots empty, input discarded.
- Async reset pulse mid-stall with skid full → outputs reach reset values immediately without waiting for a clock edge. With CNT_W=2 and 5 stall cycles, stall_cnt saturates at 3.
